regbus_mtimer: RTL
==================

Name: regbus_mtimer

Overview:
- Register-bus peripheral directly downstream of the AHB-to-register-bus slave bridge.
- Consumes the bridge's ip_addr, valid_reg_access, ip_wr1_rd0 and ip_write_data, and returns ip_read_data.
- Implements a 64-bit machine timer (mtime/mtimecmp) with a programmable prescaler and a level timer interrupt for the core.

Parameters:
- ADDR_WIDTH, 32, register-bus address width (matches the AHB address width).
- DATA_WIDTH, 32, register-bus data width (matches the AHB data width).
- OFFSET_R, 11, MSB of the offset field decoded from ip_addr (bits OFFSET_R:0).
- PRESCALE_RST, 8'h00, reset value of CTRL.prescale.

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  asynchronous active-low reset.
- ip_addr  input  ADDR_WIDTH  register address, valid while valid_reg_access=1.
- valid_reg_access  input  1  one-cycle access strobe; this cycle is the AHB data phase.
- ip_wr1_rd0  input  1  1=write, 0=read.
- ip_write_data  input  DATA_WIDTH  write data, valid while valid_reg_access=1.
- ip_read_data  output  DATA_WIDTH  read data.
- timer_int  output  1  machine timer interrupt, level.

Behaviour:
- Interface: one clock HCLK; reset HRESETn is asynchronous, active-low.
- Register map, decoded on ip_addr[OFFSET_R:0]:
  - 0x000 MTIME_LO: RW.
  - 0x004 MTIME_HI: RW; reads return hi_snap.
  - 0x008 MTIMECMP_LO: RW.
  - 0x00C MTIMECMP_HI: RW.
  - 0x010 CTRL: bit0 enable, bits[15:8] prescale, all other bits read 0.
  - 0x014 STATUS: RO; bit0 = timer_int.
  - Unmapped offsets: reads return 0, writes are ignored. Writes to STATUS are ignored.
- Read path:
  - Combinational, zero latency.
  - ip_read_data = decode(ip_addr) when valid_reg_access && !ip_wr1_rd0, else 0.
  - The bridge passes this straight to HRDATA in the same cycle.
- Write path: a write takes effect at the HCLK edge ending the cycle in which valid_reg_access && ip_wr1_rd0.
- Reset values:
  - mtime = 0, hi_snap = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - enable = 0, prescale = PRESCALE_RST, presc_cnt = 0.
  - timer_int = 0, ip_read_data = 0.
- Prescaler:
  - While enable=1: presc_cnt counts 0..prescale. tick=1 when presc_cnt==prescale, and presc_cnt then returns to 0.
  - prescale=0 gives a tick every cycle; prescale=N gives a tick every N+1 cycles.
  - While enable=0: presc_cnt is held at 0 and no tick occurs.
  - Any CTRL write clears presc_cnt.
- Counter:
  - On tick, mtime increments by 1 as a full 64-bit add with carry from LO into HI.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs tick in the same cycle:
  - A write to MTIME_LO or MTIME_HI replaces only the addressed half; the other half holds.
  - The increment is suppressed in that cycle, including any carry.
  - presc_cnt still advances normally.
- Snapshot:
  - A read of MTIME_LO loads hi_snap <= mtime[63:32] at the end of that cycle, using the pre-increment value.
  - A write of MTIME_HI loads hi_snap with the written value.
  - Software reads LO then HI to get a coherent 64-bit value.
- Interrupt:
  - timer_int is registered: timer_int <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - Latency is one cycle after mtime or mtimecmp changes.
  - timer_int stays asserted until mtimecmp is raised above mtime or mtime wraps.
- Reset mid-access: all state returns to reset values asynchronously, and the pending access is lost.
- There is no handshake or stall. The block accepts one access per cycle, back-to-back.

Decomposition:
- Shared package or header mtimer_defines.vh holds:
  - Register offset constants: MTIME_LO, MTIME_HI, MTIMECMP_LO, MTIMECMP_HI, CTRL, STATUS.
  - CTRL field positions: enable bit, prescale MSB/LSB.
- One natural sub-module, mtimer_prescaler: enable, prescale and clear inputs; tick output.
- Decode, register file and compare stay in the top module.

Test Plan:
- Reset, then read all six offsets: 0, 0, FFFFFFFF, FFFFFFFF, 0, 0. Read of 0x020 returns 0. timer_int=0.
- Write CTRL=0x0000_0301 (enable, prescale=3), wait 40 cycles: mtime advances exactly once per 4 cycles, giving 10 ±1 depending on the CTRL-write alignment.
- Write MTIME_HI=0, MTIME_LO=FFFFFFFE, CTRL=0x1, wait 2 ticks: MTIME_LO=0, MTIME_HI=1 (carry, then snapshot reads LO then HI).
- Write MTIMECMP_HI=0, MTIMECMP_LO=0x20, enable with prescale=0: timer_int rises exactly one cycle after mtime reaches 0x20, and STATUS=1. Then write MTIMECMP_LO=0xFFFF: timer_int falls one cycle later.
- Write MTIME_LO=0x100 in a cycle with tick=1: mtime=0x100 after the edge, with no extra increment, and counting resumes on the next tick.
- Read MTIME_LO when mtime=0x0000_0005_FFFF_FFFF, then read MTIME_HI after the LO carry: HI read returns 5 (snapshot), not 6. Assert HRESETn low mid-sequence: all registers return to reset values immediately.

Source files
------------

// File: rtl/regbus_mtimer_pkg.sv
// Shared definitions for the register-bus machine timer: register offsets,
// CTRL field positions and the offset-to-register decode.
package regbus_mtimer_pkg;

  // Register offsets within the peripheral window
  localparam logic [31:0] MTIME_LO    = 32'h000;
  localparam logic [31:0] MTIME_HI    = 32'h004;
  localparam logic [31:0] MTIMECMP_LO = 32'h008;
  localparam logic [31:0] MTIMECMP_HI = 32'h00C;
  localparam logic [31:0] CTRL        = 32'h010;
  localparam logic [31:0] STATUS      = 32'h014;

  // CTRL field positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_MSB = 15;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int PRESC_W        = CTRL_PRESC_MSB - CTRL_PRESC_LSB + 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_CTRL,
    SEL_STATUS
  } reg_sel_e;

  // Map a zero-extended offset onto the register it addresses
  function automatic reg_sel_e decode_offset(input logic [31:0] offset);
    reg_sel_e sel;
    case (offset)
      MTIME_LO:    sel = SEL_MTIME_LO;
      MTIME_HI:    sel = SEL_MTIME_HI;
      MTIMECMP_LO: sel = SEL_MTIMECMP_LO;
      MTIMECMP_HI: sel = SEL_MTIMECMP_HI;
      CTRL:        sel = SEL_CTRL;
      STATUS:      sel = SEL_STATUS;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: emits a one-cycle tick every
// (prescale + 1) cycles while enabled; held at zero while disabled.
module mtimer_prescaler
  import regbus_mtimer_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               i_enable,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic               i_clear,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  // Tick on the terminal count of the current prescale setting
  assign o_tick = i_enable && (r_cnt == i_prescale);

  // Prescale counter: cleared by CTRL writes, held at 0 while disabled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, regardless of order.
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/regbus_mtimer.sv
// Register-bus machine timer: 64-bit mtime/mtimecmp with prescaler, a
// read snapshot of the high word, and a registered level interrupt.
module regbus_mtimer
  import regbus_mtimer_pkg::*;
#(
  parameter int                 ADDR_WIDTH   = 32,
  parameter int                 DATA_WIDTH   = 32,
  parameter int                 OFFSET_R     = 11,
  parameter logic [PRESC_W-1:0] PRESCALE_RST = 8'h00
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] ip_addr,
  input  logic                  valid_reg_access,
  input  logic                  ip_wr1_rd0,
  input  logic [DATA_WIDTH-1:0] ip_write_data,
  output logic [DATA_WIDTH-1:0] ip_read_data,
  output logic                  timer_int
);

  localparam int TW = 2 * DATA_WIDTH;

  logic [TW-1:0]         r_mtime;
  logic [TW-1:0]         r_mtimecmp;
  logic [DATA_WIDTH-1:0] r_hi_snap;
  logic                  r_enable;
  logic [PRESC_W-1:0]    r_prescale;
  logic                  r_timer_int;

  logic [31:0]           w_offset;
  reg_sel_e              w_sel;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic                  w_unused_addr;

  // Only the offset field participates in decode; the rest of the address
  // belongs to the bridge's region select.
  assign w_offset      = 32'(ip_addr[OFFSET_R:0]);
  assign w_unused_addr = ^ip_addr[ADDR_WIDTH-1:OFFSET_R+1];
  assign w_sel         = decode_offset(w_offset);
  assign w_wr          = valid_reg_access && ip_wr1_rd0;
  assign w_rd          = valid_reg_access && !ip_wr1_rd0;
  assign timer_int     = r_timer_int;

  mtimer_prescaler u_prescaler (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .i_enable   (r_enable),
    .i_prescale (r_prescale),
    .i_clear    (w_wr && (w_sel == SEL_CTRL)),
    .o_tick     (w_tick)
  );

  // mtime: a bus write to either half wins over the tick, which is dropped
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_mtime <= '0;
    end else if (w_wr && (w_sel == SEL_MTIME_LO)) begin
      r_mtime[DATA_WIDTH-1:0] <= ip_write_data;
    end else if (w_wr && (w_sel == SEL_MTIME_HI)) begin
      r_mtime[TW-1:DATA_WIDTH] <= ip_write_data;
    end else if (w_tick) begin
      r_mtime <= r_mtime + TW'(1);
    end
  end

  // High-word snapshot so a LO-then-HI read pair is coherent across a carry
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hi_snap <= '0;
    end else if (w_rd && (w_sel == SEL_MTIME_LO)) begin
      r_hi_snap <= r_mtime[TW-1:DATA_WIDTH];
    end else if (w_wr && (w_sel == SEL_MTIME_HI)) begin
      r_hi_snap <= ip_write_data;
    end
  end

  // Compare value and control register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_mtimecmp <= '1;
      r_enable   <= 1'b0;
      r_prescale <= PRESCALE_RST;
    end else if (w_wr) begin
      case (w_sel)
        SEL_MTIMECMP_LO: r_mtimecmp[DATA_WIDTH-1:0]  <= ip_write_data;
        SEL_MTIMECMP_HI: r_mtimecmp[TW-1:DATA_WIDTH] <= ip_write_data;
        SEL_CTRL: begin
          r_enable   <= ip_write_data[CTRL_EN_BIT];
          r_prescale <= ip_write_data[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end
        default: ;
      endcase
    end
  end

  // Registered level interrupt, one cycle behind the compare operands
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_timer_int <= 1'b0;
    end else begin
      r_timer_int <= (r_mtime >= r_mtimecmp);
    end
  end

  // Zero-latency read mux; idle or write cycles drive zero
  always_comb begin
    // NOTE: the default assignment up front keeps every path driven, so no
    // latch is inferred for offsets or cycles the case does not cover.
    ip_read_data = '0;
    if (w_rd) begin
      case (w_sel)
        SEL_MTIME_LO:    ip_read_data = r_mtime[DATA_WIDTH-1:0];
        SEL_MTIME_HI:    ip_read_data = r_hi_snap;
        SEL_MTIMECMP_LO: ip_read_data = r_mtimecmp[DATA_WIDTH-1:0];
        SEL_MTIMECMP_HI: ip_read_data = r_mtimecmp[TW-1:DATA_WIDTH];
        SEL_CTRL: begin
          ip_read_data[CTRL_EN_BIT]                   = r_enable;
          ip_read_data[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = r_prescale;
        end
        SEL_STATUS:      ip_read_data[0] = r_timer_int;
        default:         ip_read_data = '0;
      endcase
    end
  end

endmodule
